// File: rtl/mmio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mmio_pkg
//  Description : Address map, status bit positions and UART state encoding
//                shared by the data-side memory subsystem.
//  Revision    : 1.0 - initial release
// ============================================================================
package mmio_pkg;

    localparam logic [31:0] ADDR_TXDATA = 32'hFFFF_0000;
    localparam logic [31:0] ADDR_STATUS = 32'hFFFF_0004;
    localparam logic [31:0] ADDR_CYCLES = 32'hFFFF_0008;

    localparam int STAT_BUSY      = 0;
    localparam int STAT_HOLD_FULL = 1;
    localparam int STAT_OVERRUN   = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    // Register decode ignores the byte offset within the word.
    function automatic logic word_match(input logic [31:0] a, input logic [31:0] b);
        return a[31:2] == b[31:2];
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx
//  Description : 8N1 serial transmitter; pulls a byte whenever load is high
//                and the line is free (idle, or at the end of a stop bit).
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx
    import mmio_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] data,
    output logic       busy,
    output logic       take,
    output logic       tx
);

    localparam int                BAUD_W      = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] C_BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    uart_state_t       r_state;
    uart_state_t       w_state_next;
    logic [BAUD_W-1:0] r_baud;
    logic [2:0]        r_bit;
    logic [7:0]        r_shift;
    logic [7:0]        w_shift_next;
    logic              r_tx;
    logic              w_tx_next;
    logic              w_baud_done;

    assign w_baud_done = (r_baud == C_BAUD_LAST);

    always_comb begin
        w_state_next = r_state;
        w_shift_next = r_shift;
        take         = 1'b0;
        case (r_state)
            IDLE: begin
                if (load) begin
                    w_state_next = START;
                    take         = 1'b1;
                end
            end
            START: begin
                if (w_baud_done) w_state_next = DATA;
            end
            DATA: begin
                if (w_baud_done) begin
                    w_shift_next = {1'b0, r_shift[7:1]};
                    if (r_bit == 3'd7) w_state_next = STOP;
                end
            end
            STOP: begin
                if (w_baud_done) begin
                    if (load) begin
                        w_state_next = START;
                        take         = 1'b1;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
        if (take) w_shift_next = data;
        // Line level is registered from the state being entered.
        case (w_state_next)
            START:   w_tx_next = 1'b0;
            DATA:    w_tx_next = w_shift_next[0];
            default: w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_shift <= w_shift_next;
            r_tx    <= w_tx_next;
            if (r_state == IDLE || w_baud_done) r_baud <= '0;
            else                                r_baud <= r_baud + 1'b1;
            if (r_state == DATA && w_baud_done) r_bit <= r_bit + 3'd1;
        end
    end

    assign busy = (r_state != IDLE);
    assign tx   = r_tx;

endmodule
`default_nettype wire

// File: rtl/dmem_mmio.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_mmio
//  Description : Word-addressed data RAM plus UART TX data/status and cycle
//                counter registers for the single-cycle core.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_mmio
    import mmio_pkg::*;
#(
    parameter int RAM_WORDS    = 256,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        uart_tx
);

    localparam int IDX_W = $clog2(RAM_WORDS);

    logic [31:0]      r_ram [RAM_WORDS];
    logic [IDX_W-1:0] w_idx;
    logic             w_is_ram;
    logic             w_is_tx;
    logic             w_is_stat;
    logic             w_is_cyc;
    logic             w_unused_bits;

    logic [7:0]       r_hold_data;
    logic             r_hold_full;
    logic             r_overrun;
    logic [31:0]      r_cycles;
    logic [31:0]      w_status;
    logic             w_busy;
    logic             w_take;

    assign w_idx         = addr[IDX_W+1:2];
    assign w_is_ram      = (addr[31:IDX_W+2] == '0);
    assign w_is_tx       = word_match(addr, ADDR_TXDATA);
    assign w_is_stat     = word_match(addr, ADDR_STATUS);
    assign w_is_cyc      = word_match(addr, ADDR_CYCLES);
    assign w_unused_bits = ^addr[1:0];

    always_ff @(posedge clk) begin
        if (memwrite && w_is_ram) r_ram[w_idx] <= writedata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_data <= '0;
            r_hold_full <= 1'b0;
            r_overrun   <= 1'b0;
            r_cycles    <= '0;
        end else begin
            r_cycles <= (memwrite && w_is_cyc) ? writedata : r_cycles + 32'd1;
            // A transfer frees the slot in the same cycle, so a colliding write lands.
            if (memwrite && w_is_tx) begin
                if (!r_hold_full || w_take) begin
                    r_hold_data <= writedata[7:0];
                    r_hold_full <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (w_take) begin
                r_hold_full <= 1'b0;
            end
            if (memwrite && w_is_stat && writedata[STAT_OVERRUN]) r_overrun <= 1'b0;
        end
    end

    always_comb begin
        w_status                 = '0;
        w_status[STAT_BUSY]      = w_busy;
        w_status[STAT_HOLD_FULL] = r_hold_full;
        w_status[STAT_OVERRUN]   = r_overrun;
    end

    always_comb begin
        readdata = '0;
        if (w_is_ram)       readdata = r_ram[w_idx];
        else if (w_is_stat) readdata = w_status;
        else if (w_is_cyc)  readdata = r_cycles;
    end

    uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart (
        .clk  (clk),
        .rst  (rst),
        .load (r_hold_full),
        .data (r_hold_data),
        .busy (w_busy),
        .take (w_take),
        .tx   (uart_tx)
    );

endmodule
`default_nettype wire
